// File: rtl/oled_init_sequencer.sv
// Power-on and initialisation sequencer for an SSD1306-class Pmod OLED.
// Drives the panel rails/reset and streams an 11-byte command ROM through spi_master.
module oled_init_sequencer #(
  parameter int DLY_VDD     = 20000,
  parameter int DLY_RES     = 60,
  parameter int DLY_VBAT    = 2000000,
  parameter int SPI_TIMEOUT = 4096,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [3:0] cmd_idx,
  output logic       spi_start,
  output logic [7:0] spi_data,
  input  logic       spi_done,
  output logic       oled_dc,
  output logic       oled_res,
  output logic       oled_vbat,
  output logic       oled_vdd
);

  typedef enum logic [3:0] {
    S_IDLE, S_PWR_VDD, S_CMD_A, S_RES_LO, S_RES_HI,
    S_CMD_B, S_PWR_VBAT, S_CMD_C, S_DONE, S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] L_VDD  = CNT_W'(DLY_VDD - 1);
  localparam logic [CNT_W-1:0] L_RES  = CNT_W'(DLY_RES - 1);
  localparam logic [CNT_W-1:0] L_VBAT = CNT_W'(DLY_VBAT - 1);
  localparam logic [CNT_W-1:0] L_TMO  = CNT_W'(SPI_TIMEOUT - 1);

  function automatic logic [7:0] rom_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    rom_byte = 8'hAE;
      4'd1:    rom_byte = 8'h8D;
      4'd2:    rom_byte = 8'h14;
      4'd3:    rom_byte = 8'hD9;
      4'd4:    rom_byte = 8'hF1;
      4'd5:    rom_byte = 8'hA1;
      4'd6:    rom_byte = 8'hC8;
      4'd7:    rom_byte = 8'hDA;
      4'd8:    rom_byte = 8'h20;
      4'd9:    rom_byte = 8'h81;
      4'd10:   rom_byte = 8'hAF;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  state_t           r_state, w_state_nxt;
  logic             r_wait, w_wait_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_idx, w_idx_nxt;
  logic             r_oled_res, r_oled_vbat, r_oled_vdd;

  logic [3:0]       w_last;
  state_t           w_follow;
  logic [CNT_W-1:0] w_follow_cnt;
  logic             w_is_cmd;
  logic             w_vdd_on, w_vbat_on, w_res_lo;

  assign w_is_cmd = (r_state inside {S_CMD_A, S_CMD_B, S_CMD_C});

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait;
    w_cnt_nxt    = r_cnt;
    w_idx_nxt    = r_idx;
    w_last       = 4'd0;
    w_follow     = S_IDLE;
    w_follow_cnt = '0;

    case (r_state)
      S_CMD_A: begin w_last = 4'd0;  w_follow = S_RES_LO;   w_follow_cnt = L_RES;  end
      S_CMD_B: begin w_last = 4'd4;  w_follow = S_PWR_VBAT; w_follow_cnt = L_VBAT; end
      S_CMD_C: begin w_last = 4'd10; w_follow = S_DONE;     w_follow_cnt = '0;     end
      default: ;
    endcase

    case (r_state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          w_state_nxt = S_PWR_VDD;
          w_cnt_nxt   = L_VDD;
          w_idx_nxt   = 4'd0;
          w_wait_nxt  = 1'b0;
        end
      end
      S_PWR_VDD: begin
        if (r_cnt == '0) w_state_nxt = S_CMD_A;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_RES_LO: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RES_HI;
          w_cnt_nxt   = L_RES;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      S_RES_HI: begin
        if (r_cnt == '0) w_state_nxt = S_CMD_B;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_PWR_VBAT: begin
        if (r_cnt == '0) w_state_nxt = S_CMD_C;
        else             w_cnt_nxt   = r_cnt - 1'b1;
      end
      S_CMD_A, S_CMD_B, S_CMD_C: begin
        if (!r_wait) begin
          w_wait_nxt = 1'b1;
          w_cnt_nxt  = L_TMO;
        end else if (spi_done) begin
          w_wait_nxt = 1'b0;
          w_idx_nxt  = r_idx + 4'd1;
          if (r_idx == w_last) begin
            w_state_nxt = w_follow;
            w_cnt_nxt   = w_follow_cnt;
          end
        end else if (r_cnt == '0) begin
          w_state_nxt = S_FAULT;
          w_wait_nxt  = 1'b0;
        end else begin
          w_cnt_nxt   = r_cnt - 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pins are registered from the next state; on a fault VBAT drops with the
  // state change while VDD follows one cycle later.
  assign w_vdd_on  = (w_state_nxt inside {S_PWR_VDD, S_CMD_A, S_RES_LO, S_RES_HI,
                                          S_CMD_B, S_PWR_VBAT, S_CMD_C, S_DONE})
                  || (w_state_nxt == S_FAULT && r_state != S_FAULT);
  assign w_vbat_on = (w_state_nxt inside {S_PWR_VBAT, S_CMD_C, S_DONE});
  assign w_res_lo  = (w_state_nxt inside {S_RES_LO, S_FAULT});

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wait      <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= 4'd0;
      r_oled_res  <= 1'b1;
      r_oled_vbat <= 1'b1;
      r_oled_vdd  <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_wait      <= w_wait_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_oled_res  <= ~w_res_lo;
      r_oled_vbat <= ~w_vbat_on;
      r_oled_vdd  <= ~w_vdd_on;
    end
  end

  assign busy      = (r_state inside {S_PWR_VDD, S_CMD_A, S_RES_LO, S_RES_HI,
                                      S_CMD_B, S_PWR_VBAT, S_CMD_C});
  assign done      = (r_state == S_DONE);
  assign fault     = (r_state == S_FAULT);
  assign cmd_idx   = r_idx;
  assign spi_start = w_is_cmd && !r_wait;
  assign spi_data  = w_is_cmd ? rom_byte(r_idx) : 8'h00;
  assign oled_dc   = 1'b0;
  assign oled_res  = r_oled_res;
  assign oled_vbat = r_oled_vbat;
  assign oled_vdd  = r_oled_vdd;

endmodule
